// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect player.
package sfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EAT,
    ST_FAIL,
    ST_WIN
  } sfx_state_t;

  // Success arpeggio half-periods in clk cycles at 25.175 MHz.
  localparam logic [15:0] NOTE_C5 = 16'd24056;
  localparam logic [15:0] NOTE_E5 = 16'd19094;
  localparam logic [15:0] NOTE_G5 = 16'd16056;
  localparam logic [15:0] NOTE_C6 = 16'd12028;

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: toggles its output every half_period clk cycles.
module sfx_tone_gen #(
  parameter int HP_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_restart,
  input  logic [HP_W-1:0] i_half_period,
  output logic            o_wave
);

  logic [HP_W-1:0] r_cnt;
  logic            r_wave;
  logic            w_wrap;

  // >= rather than == so a half-period that shrinks below the running count
  // wraps at the next compare instead of running off to the counter limit.
  always_comb begin
    w_wrap = (i_half_period <= HP_W'(1)) || (r_cnt >= (i_half_period - HP_W'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_wave <= ~r_wave;
    end else begin
      r_cnt  <= r_cnt + HP_W'(1);
    end
  end

  assign o_wave = r_wave;

endmodule

// File: rtl/sfx_player.sv
// Sound-effect player: eat beep, failure sweep and success arpeggio on a
// 1-bit square-wave pin, sequenced by vsync frames.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int HP_W            = 16,
  parameter int EAT_HALF_PERIOD = 12587,
  parameter int EAT_FRAMES      = 6,
  parameter int FAIL_START_HP   = 25175,
  parameter int FAIL_STEP       = 1024,
  parameter int FAIL_FRAMES     = 30,
  parameter int WIN_NOTE_FRAMES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_eat,
  input  logic i_failure,
  input  logic i_success,
  input  logic i_vsync,
  input  logic i_mute,
  output logic o_audio,
  output logic o_busy
);

  localparam int WIN_FRAMES = 4 * WIN_NOTE_FRAMES;
  localparam int MAX_EF     = (EAT_FRAMES > FAIL_FRAMES) ? EAT_FRAMES : FAIL_FRAMES;
  localparam int MAX_FRAMES = (MAX_EF > WIN_FRAMES) ? MAX_EF : WIN_FRAMES;
  localparam int FC_W       = $clog2(MAX_FRAMES + 1);

  sfx_state_t      r_state, w_state_next;
  logic            r_fail_d, r_succ_d, r_vsync_d;
  logic            w_fail_rise, w_fail_fall, w_succ_rise, w_succ_fall, w_frame;
  logic [FC_W-1:0] r_frame_cnt, w_frame_next, w_frame_inc, w_frame_limit;
  logic [FC_W-1:0] w_note_div;
  logic [1:0]      w_note_idx;
  logic [HP_W:0]   w_fail_sum;
  logic [HP_W-1:0] w_fail_hp, w_note_hp, w_half_period;
  logic            w_restart, w_wave;

  always_comb begin
    w_fail_rise = i_failure & ~r_fail_d;
    w_fail_fall = ~i_failure & r_fail_d;
    w_succ_rise = i_success & ~r_succ_d;
    w_succ_fall = ~i_success & r_succ_d;
    w_frame     = i_vsync & ~r_vsync_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_d  <= 1'b0;
      r_succ_d  <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_fail_d  <= i_failure;
      r_succ_d  <= i_success;
      r_vsync_d <= i_vsync;
    end
  end

  always_comb begin
    w_frame_inc = r_frame_cnt + FC_W'(1);
    unique case (r_state)
      ST_EAT:  w_frame_limit = FC_W'(EAT_FRAMES);
      ST_FAIL: w_frame_limit = FC_W'(FAIL_FRAMES);
      ST_WIN:  w_frame_limit = FC_W'(WIN_FRAMES);
      default: w_frame_limit = '0;
    endcase
  end

  // Events outrank aborts and frame ticks, so an event coinciding with a
  // frame edge restarts the count at zero.
  always_comb begin
    w_state_next = r_state;
    w_frame_next = r_frame_cnt;
    w_restart    = (r_state == ST_IDLE);
    if (w_fail_rise) begin
      w_state_next = ST_FAIL;
      w_frame_next = '0;
      w_restart    = 1'b1;
    end else if (w_succ_rise && (r_state == ST_IDLE || r_state == ST_EAT)) begin
      w_state_next = ST_WIN;
      w_frame_next = '0;
      w_restart    = 1'b1;
    end else if (i_eat && (r_state == ST_IDLE || r_state == ST_EAT)) begin
      w_state_next = ST_EAT;
      w_frame_next = '0;
      w_restart    = 1'b1;
    end else if ((r_state == ST_FAIL && w_fail_fall) || (r_state == ST_WIN && w_succ_fall)) begin
      w_state_next = ST_IDLE;
      w_frame_next = '0;
    end else if (r_state != ST_IDLE && w_frame) begin
      w_frame_next = w_frame_inc;
      if (w_frame_inc == w_frame_limit) begin
        w_state_next = ST_IDLE;
        w_frame_next = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_frame_cnt <= w_frame_next;
    end
  end

  always_comb begin
    w_fail_sum = (HP_W+1)'(FAIL_START_HP) + (HP_W+1)'(FAIL_STEP) * (HP_W+1)'(r_frame_cnt);
    w_fail_hp  = w_fail_sum[HP_W] ? '1 : w_fail_sum[HP_W-1:0];
    w_note_div = r_frame_cnt / FC_W'(WIN_NOTE_FRAMES);
    w_note_idx = (w_note_div > FC_W'(3)) ? 2'd3 : w_note_div[1:0];
    unique case (w_note_idx)
      2'd0:    w_note_hp = HP_W'(NOTE_C5);
      2'd1:    w_note_hp = HP_W'(NOTE_E5);
      2'd2:    w_note_hp = HP_W'(NOTE_G5);
      default: w_note_hp = HP_W'(NOTE_C6);
    endcase
    unique case (r_state)
      ST_EAT:  w_half_period = HP_W'(EAT_HALF_PERIOD);
      ST_FAIL: w_half_period = w_fail_hp;
      ST_WIN:  w_half_period = w_note_hp;
      default: w_half_period = '0;
    endcase
  end

  sfx_tone_gen #(
    .HP_W(HP_W)
  ) u_tone (
    .clk          (clk),
    .rst          (rst),
    .i_restart    (w_restart),
    .i_half_period(w_half_period),
    .o_wave       (w_wave)
  );

  assign o_busy  = (r_state != ST_IDLE);
  assign o_audio = w_wave & o_busy & ~i_mute;

endmodule

// File: tb/tb_sfx_player.sv
// Randomized scoreboard bench for sfx_player against a behavioural model.
module tb_sfx_player;

  localparam int HP_W    = 16;
  localparam int EAT_HP  = 4;
  localparam int EAT_FR  = 2;
  localparam int F_START = 8;
  localparam int F_STEP  = 2;
  localparam int F_FR    = 3;
  localparam int WNF     = 1;
  localparam int VS_HALF = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_eat = 1'b0, i_failure = 1'b0, i_success = 1'b0, i_vsync = 1'b0, i_mute = 1'b0;
  logic o_audio, o_busy, sat_audio, sat_busy;

  sfx_player #(
    .HP_W(HP_W), .EAT_HALF_PERIOD(EAT_HP), .EAT_FRAMES(EAT_FR), .FAIL_START_HP(F_START),
    .FAIL_STEP(F_STEP), .FAIL_FRAMES(F_FR), .WIN_NOTE_FRAMES(WNF)
  ) dut (
    .clk(clk), .rst(rst), .i_eat(i_eat), .i_failure(i_failure), .i_success(i_success),
    .i_vsync(i_vsync), .i_mute(i_mute), .o_audio(o_audio), .o_busy(o_busy)
  );

  sfx_player #(
    .HP_W(HP_W), .EAT_HALF_PERIOD(EAT_HP), .EAT_FRAMES(EAT_FR), .FAIL_START_HP(65000),
    .FAIL_STEP(1024), .FAIL_FRAMES(F_FR), .WIN_NOTE_FRAMES(WNF)
  ) dut_sat (
    .clk(clk), .rst(rst), .i_eat(i_eat), .i_failure(i_failure), .i_success(i_success),
    .i_vsync(i_vsync), .i_mute(i_mute), .o_audio(sat_audio), .o_busy(sat_busy)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_EAT, M_FAIL, M_WIN} mode_t;
  typedef struct {
    bit busy;
    bit audio;
    int hp;
    int hp_sat;
    bit in_fail;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    notes[4] = '{24056, 19094, 16056, 12028};

  mode_t m_st = M_IDLE;
  int    m_fc = 0, m_t = 0;
  bit    m_wave = 0, m_pf = 0, m_ps = 0, m_pv = 0;
  bit    s_fail = 0, s_succ = 0, s_mute = 0;
  int    vs_cnt = 0;

  function automatic int hp_of(mode_t st, int fc, int start, int step);
    int v;
    case (st)
      M_EAT:  return EAT_HP;
      M_FAIL: begin v = start + step * fc; return (v > 65535) ? 65535 : v; end
      M_WIN:  begin v = fc / WNF; if (v > 3) v = 3; return notes[v]; end
      default: return 0;
    endcase
  endfunction

  function automatic int frames_of(mode_t st);
    case (st)
      M_EAT:  return EAT_FR;
      M_FAIL: return F_FR;
      M_WIN:  return 4 * WNF;
      default: return 0;
    endcase
  endfunction

  // Predicts the outputs just after the coming posedge from the inputs now driven.
  task automatic model_step(input bit eat);
    bit fr, ff, sr, sf, fe;
    int ent, hp;
    exp_t e;
    fr = i_failure && !m_pf;  ff = !i_failure && m_pf;
    sr = i_success && !m_ps;  sf = !i_success && m_ps;
    fe = i_vsync && !m_pv;
    m_pf = i_failure; m_ps = i_success; m_pv = i_vsync;
    ent = -1;
    if (fr) ent = M_FAIL;
    else if (sr && (m_st == M_IDLE || m_st == M_EAT)) ent = M_WIN;
    else if (eat && (m_st == M_IDLE || m_st == M_EAT)) ent = M_EAT;
    if (ent >= 0) begin
      m_st = mode_t'(ent); m_fc = 0; m_t = 0; m_wave = 0;
    end else if ((m_st == M_FAIL && ff) || (m_st == M_WIN && sf)) begin
      m_st = M_IDLE;
    end else if (m_st != M_IDLE) begin
      hp = hp_of(m_st, m_fc, F_START, F_STEP);
      if (m_t + 1 >= hp) begin m_t = 0; m_wave = !m_wave; end
      else m_t = m_t + 1;
      if (fe) begin
        m_fc = m_fc + 1;
        if (m_fc == frames_of(m_st)) begin m_st = M_IDLE; m_fc = 0; end
      end
    end
    e.busy    = (m_st != M_IDLE);
    e.audio   = m_wave && e.busy && !i_mute;
    e.hp      = hp_of(m_st, m_fc, F_START, F_STEP);
    e.hp_sat  = hp_of(m_st, m_fc, 65000, 1024);
    e.in_fail = (m_st == M_FAIL);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit eat);
    @(negedge clk);
    rst = 1'b0;
    vs_cnt = vs_cnt + 1;
    if (vs_cnt == VS_HALF) begin vs_cnt = 0; i_vsync = ~i_vsync; end
    i_eat = eat; i_failure = s_fail; i_success = s_succ; i_mute = s_mute;
    model_step(eat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    #2 rst = 1'b1;
    m_st = M_IDLE; m_fc = 0; m_t = 0; m_wave = 0; m_pf = 0; m_ps = 0; m_pv = 0;
    e.busy = 0; e.audio = 0; e.hp = 0; e.hp_sat = 0; e.in_fail = 0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   from_clk;
    forever begin
      @(posedge clk or posedge rst);
      from_clk = clk;
      #1;
      if (!from_clk) begin
        chk("async_rst_busy", o_busy, 0);
        chk("async_rst_audio", o_audio, 0);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("busy", o_busy, e.busy);
        chk("audio", o_audio, e.audio);
        chk("sat_busy", sat_busy, e.busy);
        chk("sat_audio", sat_audio, e.in_fail ? 0 : e.audio);
        if (e.busy) begin
          chk("half_period", dut.w_half_period, e.hp);
          chk("sat_half_period", dut_sat.w_half_period, e.hp_sat);
        end
      end
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    idle(500);
    cyc(1'b1); idle(250);
    cyc(1'b1); idle(120); cyc(1'b1); idle(250);
    cyc(1'b1); idle(20);
    s_fail = 1; cyc(1'b0);
    for (int i = 0; i < 400; i++) cyc(i % 37 == 0);
    s_fail = 0; idle(20);
    s_fail = 1; idle(60); s_fail = 0; idle(20);
    s_succ = 1; idle(450); s_succ = 0; idle(20);
    s_succ = 1; idle(150); s_succ = 0; idle(20);
    s_mute = 1; cyc(1'b1); idle(100); s_mute = 0; idle(150);
    cyc(1'b1); idle(30);
    do_reset();
    idle(40);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299, 0) == 0) s_fail = ~s_fail;
      if ($urandom_range(299, 0) == 0) s_succ = ~s_succ;
      if ($urandom_range(99, 0) == 0)  s_mute = ~s_mute;
      if (i == 1500) do_reset();
      cyc($urandom_range(39, 0) == 0);
    end
    idle(5);
    repeat (2) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
